fetch_stage: RTL and testbench



---
 rtl/mips_pipe_pkg.sv | 33 +++
 rtl/fetch_stage_if_id_reg.sv | 66 ++++++
 rtl/fetch_stage.sv | 155 +++++++++++++++
 tb/tb_fetch_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
//   Shared definitions for the 2-bit-opcode MIPS pipeline:
//     - opcode encodings (ALU, immediate, jump)
//     - NOP_INSTR: the bubble loaded into IF/ID (opcode 11, suppresses writeReg)
//     - fetch_state_e: fetch FSM states
//     - default PC / instruction widths
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

   localparam int PC_W_DEF    = 8;
   localparam int INSTR_W_DEF = 8;

   typedef enum logic [1:0] {
      OPC_ALU = 2'b00,
      OPC_IMM = 2'b01,
      OPC_JMP = 2'b11
   } opcode_e;

   localparam logic [7:0] NOP_INSTR = 8'hC0;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

   // Saturating 16-bit increment used by the optional performance counters.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register holding the fetched instruction, its PC and a
//   valid bit.
//   Ports:
//     clk, reset      : clock, synchronous active-high reset (loads NOP)
//     load_en         : capture instr_in/pc_in as a valid instruction
//     load_nop        : load NOP, pc 0, valid 0 (wins over load_en)
//     instr_in, pc_in : instruction and PC from the IF stage
//     id_instr, id_pc, id_valid : register outputs into ID
//   With neither load_en nor load_nop the register holds (stall).
// -----------------------------------------------------------------------------
module if_id_reg
   import mips_pipe_pkg::*;
#(
   parameter int                   PC_W    = PC_W_DEF,
   parameter int                   INSTR_W = INSTR_W_DEF,
   parameter logic [INSTR_W-1:0]   NOP     = NOP_INSTR
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_en,
   input  logic               load_nop,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [PC_W-1:0]    pc_in,
   output logic [INSTR_W-1:0] id_instr,
   output logic [PC_W-1:0]    id_pc,
   output logic               id_valid
);

   logic [INSTR_W-1:0] instr_d, instr_q;
   logic [PC_W-1:0]    pc_d, pc_q;
   logic               valid_d, valid_q;

   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (load_nop) begin
         instr_d = NOP;
         pc_d    = '0;
         valid_d = 1'b0;
      end else if (load_en) begin
         instr_d = instr_in;
         pc_d    = pc_in;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q <= NOP;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign id_instr = instr_q;
   assign id_pc    = pc_q;
   assign id_valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   IF stage plus IF/ID register. Holds the PC, addresses a combinational-read
//   instruction memory, hands the IF opcode to the control unit and takes back
//   pc_jump_sel, then registers instruction/PC/valid into ID.
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     stall        : hold PC and IF/ID
//     flush        : load NOP into IF/ID (overrides stall for IF/ID only)
//     pc_jump_sel  : take jump target this cycle
//     imem_addr    : instruction address (= PC)
//     imem_rdata   : instruction at imem_addr, same cycle
//     if_opcode    : opcode being fetched (00 outside RUN)
//     id_instr, id_opcode, id_pc, id_valid : IF/ID contents
//     halted       : HALTED state reached
//   Optional feature, macro FETCH_PERF_CNT_EN: adds saturating 16-bit
//   perf_fetch_cnt (normal IF/ID loads) and perf_jump_cnt (jumps taken).
//   The FSM state is held in state_q (fetch_state_e) for observation.
// -----------------------------------------------------------------------------
module fetch_stage
   import mips_pipe_pkg::*;
#(
   parameter int                 PC_W       = PC_W_DEF,
   parameter int                 INSTR_W    = INSTR_W_DEF,
   parameter logic [PC_W-1:0]    RESET_PC   = '0,
   parameter logic [INSTR_W-1:0] HALT_INSTR = 8'hFF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic               pc_jump_sel,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [1:0]         if_opcode,
   output logic [INSTR_W-1:0] id_instr,
   output logic [1:0]         id_opcode,
   output logic [PC_W-1:0]    id_pc,
   output logic               id_valid,
   output logic               halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]        perf_fetch_cnt,
   output logic [15:0]        perf_jump_cnt
`endif
);

   // Jump target keeps the PC bits above the instruction's target field.
   localparam int TGT_W = INSTR_W - 2;

   fetch_state_e    state_d, state_q;
   logic [PC_W-1:0] pc_d, pc_q;
   logic            halted_d, halted_q;

   logic            run;
   logic            halting;
   logic            take_jump;
   logic [PC_W-1:0] jump_target;

   assign run         = (state_q == RUN);
   assign halting     = run && !stall && (imem_rdata == HALT_INSTR);
   assign take_jump   = run && !stall && !halting && pc_jump_sel;
   assign jump_target = {pc_q[PC_W-1:TGT_W], imem_rdata[TGT_W-1:0]};

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      halted_d = halted_q;
      case (state_q)
         BOOT: begin
            // Single settling cycle; stall cannot stretch it.
            state_d = RUN;
         end
         RUN: begin
            if (halting) begin
               state_d  = HALTED;
               halted_d = 1'b1;
            end else if (!stall) begin
               pc_d = take_jump ? jump_target : pc_q + PC_W'(1);
            end
         end
         HALTED: begin
            // Frozen until reset.
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= BOOT;
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         halted_q <= halted_d;
      end
   end

   assign imem_addr = pc_q;
   assign halted    = halted_q;
   // Outside RUN the control unit must see a non-jump opcode.
   assign if_opcode = run ? imem_rdata[INSTR_W-1:INSTR_W-2] : OPC_ALU;

   // BOOT and HALTED feed bubbles; in RUN the halt instruction itself
   // is loaded as a valid instruction on the halting edge.
   if_id_reg #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W)
   ) u_if_id_reg (
      .clk      (clk),
      .reset    (reset),
      .load_en  (run && !stall),
      .load_nop (flush || !run),
      .instr_in (imem_rdata),
      .pc_in    (pc_q),
      .id_instr (id_instr),
      .id_pc    (id_pc),
      .id_valid (id_valid)
   );

   assign id_opcode = id_instr[INSTR_W-1:INSTR_W-2];

`ifdef FETCH_PERF_CNT_EN
   logic        normal_load;
   logic [15:0] fetch_cnt_d, fetch_cnt_q;
   logic [15:0] jump_cnt_d, jump_cnt_q;

   assign normal_load = run && !stall && !flush;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      jump_cnt_d  = jump_cnt_q;
      if (normal_load) fetch_cnt_d = sat_inc16(fetch_cnt_q);
      if (take_jump)   jump_cnt_d  = sat_inc16(jump_cnt_q);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_q <= '0;
         jump_cnt_q  <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         jump_cnt_q  <= jump_cnt_d;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_jump_cnt  = jump_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed vector table for the documented fetch sequence, a PC wrap sweep,
//   and randomized stall/flush/jump/reset traffic checked against a behavioural
//   model. Build with +define+FETCH_PERF_CNT_EN to include the counters.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
   import mips_pipe_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1;
   logic       stall = 1'b0;
   logic       flush = 1'b0;
   logic       force_j = 1'b0;
   logic       pc_jump_sel;
   logic [7:0] imem_addr;
   logic [7:0] imem_rdata;
   logic [1:0] if_opcode;
   logic [7:0] id_instr;
   logic [1:0] id_opcode;
   logic [7:0] id_pc;
   logic       id_valid;
   logic       halted;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] perf_fetch_cnt;
   logic [15:0] perf_jump_cnt;
`endif

   logic [7:0] mem [256];
   assign imem_rdata  = mem[imem_addr];
   // Control unit stand-in: jump on opcode 11, or when the bench forces it.
   assign pc_jump_sel = force_j | (if_opcode == OPC_JMP);

   fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .flush       (flush),
      .pc_jump_sel (pc_jump_sel),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .if_opcode   (if_opcode),
      .id_instr    (id_instr),
      .id_opcode   (id_opcode),
      .id_pc       (id_pc),
      .id_valid    (id_valid),
      .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_jump_cnt  (perf_jump_cnt)
`endif
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [25:0] exp_q[$];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   // ---------------- behavioural model ----------------
   logic        m_boot, m_halt, m_valid;
   logic [7:0]  m_pc, m_instr, m_idpc;
   logic [15:0] m_fcnt, m_jcnt;

   task automatic m_reset();
      m_boot = 1'b1; m_halt = 1'b0; m_pc = 8'h00;
      m_instr = NOP_INSTR; m_idpc = 8'h00; m_valid = 1'b0;
      m_fcnt = 16'd0; m_jcnt = 16'd0;
   endtask

   task automatic m_step(input logic s, input logic f, input logic fj);
      logic [7:0] ins;
      logic       stop;
      if (m_boot) begin
         m_boot = 1'b0;
         m_instr = NOP_INSTR; m_idpc = 8'h00; m_valid = 1'b0;
      end else if (m_halt) begin
         m_instr = NOP_INSTR; m_idpc = 8'h00; m_valid = 1'b0;
      end else begin
         ins  = mem[m_pc];
         stop = !s && (ins == 8'hFF);
         if (f) begin
            m_instr = NOP_INSTR; m_idpc = 8'h00; m_valid = 1'b0;
         end else if (!s) begin
            m_instr = ins; m_idpc = m_pc; m_valid = 1'b1;
            if (m_fcnt != 16'hFFFF) m_fcnt++;
         end
         if (stop) m_halt = 1'b1;
         else if (!s) begin
            if (fj || ins[7:6] == 2'b11) begin
               m_pc = (m_pc & 8'hC0) | (ins & 8'h3F);
               if (m_jcnt != 16'hFFFF) m_jcnt++;
            end else begin
               m_pc = m_pc + 8'd1;
            end
         end
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       stall;
      logic       flush;
      logic       fj;
      logic [7:0] addr;
      logic [7:0] instr;
      logic [7:0] pc;
      logic       valid;
      logic       halted;
      logic [1:0] opc;
   } vec_t;

   vec_t vt[16];

   initial begin
      logic [25:0] e;
      logic        rst_r, s_r, f_r, fj_r;
      logic [1:0]  exp_opc;

      vt[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'hC0, 8'h00, 1'b0, 1'b0, 2'b00};
      vt[1]  = '{1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0, 2'b01};
      vt[2]  = '{1'b0, 1'b0, 1'b0, 8'h02, 8'h42, 8'h01, 1'b1, 1'b0, 2'b00};
      vt[3]  = '{1'b0, 1'b0, 1'b0, 8'h03, 8'h05, 8'h02, 1'b1, 1'b0, 2'b11};
      vt[4]  = '{1'b0, 1'b0, 1'b0, 8'h09, 8'hC9, 8'h03, 1'b1, 1'b0, 2'b11};
      vt[5]  = '{1'b0, 1'b0, 1'b0, 8'h05, 8'hC5, 8'h09, 1'b1, 1'b0, 2'b00};
      vt[6]  = '{1'b1, 1'b0, 1'b1, 8'h05, 8'hC5, 8'h09, 1'b1, 1'b0, 2'b00};
      vt[7]  = '{1'b1, 1'b0, 1'b1, 8'h05, 8'hC5, 8'h09, 1'b1, 1'b0, 2'b00};
      vt[8]  = '{1'b0, 1'b0, 1'b0, 8'h06, 8'h03, 8'h05, 1'b1, 1'b0, 2'b11};
      vt[9]  = '{1'b0, 1'b0, 1'b0, 8'h10, 8'hD0, 8'h06, 1'b1, 1'b0, 2'b00};
      vt[10] = '{1'b1, 1'b1, 1'b0, 8'h10, 8'hC0, 8'h00, 1'b0, 1'b0, 2'b00};
      vt[11] = '{1'b0, 1'b0, 1'b0, 8'h11, 8'h07, 8'h10, 1'b1, 1'b0, 2'b11};
      vt[12] = '{1'b0, 1'b0, 1'b0, 8'h20, 8'hE0, 8'h11, 1'b1, 1'b0, 2'b11};
      vt[13] = '{1'b0, 1'b0, 1'b0, 8'h20, 8'hFF, 8'h20, 1'b1, 1'b1, 2'b00};
      vt[14] = '{1'b0, 1'b1, 1'b0, 8'h20, 8'hC0, 8'h00, 1'b0, 1'b1, 2'b00};
      vt[15] = '{1'b0, 1'b0, 1'b1, 8'h20, 8'hC0, 8'h00, 1'b0, 1'b1, 2'b00};

      // ---- phase A: documented sequence ----
      clear_mem();
      mem[8'h00] = 8'h01; mem[8'h01] = 8'h42; mem[8'h02] = 8'h05; mem[8'h03] = 8'hC9;
      mem[8'h05] = 8'h03; mem[8'h06] = 8'hD0; mem[8'h09] = 8'hC5;
      mem[8'h10] = 8'h07; mem[8'h11] = 8'hE0; mem[8'h20] = 8'hFF;

      reset = 1'b1;
      tick();
      tick();
      chk("rst_addr",   16'(imem_addr), 16'h00);
      chk("rst_instr",  16'(id_instr),  16'hC0);
      chk("rst_valid",  16'(id_valid),  16'h0);
      chk("rst_idpc",   16'(id_pc),     16'h00);
      chk("rst_halted", 16'(halted),    16'h0);
      chk("rst_ifopc",  16'(if_opcode), 16'h0);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         stall = vt[i].stall; flush = vt[i].flush; force_j = vt[i].fj;
         tick();
         chk($sformatf("v%0d_addr", i),   16'(imem_addr), 16'(vt[i].addr));
         chk($sformatf("v%0d_instr", i),  16'(id_instr),  16'(vt[i].instr));
         chk($sformatf("v%0d_idopc", i),  16'(id_opcode), 16'(vt[i].instr[7:6]));
         chk($sformatf("v%0d_idpc", i),   16'(id_pc),     16'(vt[i].pc));
         chk($sformatf("v%0d_valid", i),  16'(id_valid),  16'(vt[i].valid));
         chk($sformatf("v%0d_halted", i), 16'(halted),    16'(vt[i].halted));
         chk($sformatf("v%0d_ifopc", i),  16'(if_opcode), 16'(vt[i].opc));
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch_a", perf_fetch_cnt, 16'd10);
      chk("perf_jump_a",  perf_jump_cnt,  16'd4);
`endif
      stall = 1'b0; flush = 1'b0; force_j = 1'b0;
      reset = 1'b1;
      tick();
      chk("rerst_addr",   16'(imem_addr), 16'h00);
      chk("rerst_halted", 16'(halted),    16'h0);
      chk("rerst_valid",  16'(id_valid),  16'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("rerst_perf_f", perf_fetch_cnt, 16'd0);
      chk("rerst_perf_j", perf_jump_cnt,  16'd0);
`endif

      // ---- phase B: sequential sweep through PC wrap ----
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) & 8'h3F;
      reset = 1'b0;
      tick();
      chk("boot_addr", 16'(imem_addr), 16'h00);
      for (int i = 0; i < 257; i++) begin
         tick();
         chk("sweep_addr",  16'(imem_addr), 16'((i + 1) & 8'hFF));
         chk("sweep_idpc",  16'(id_pc),     16'(i & 8'hFF));
         chk("sweep_instr", 16'(id_instr),  16'(i & 8'h3F));
      end

      // ---- phase C: random traffic vs behavioural model ----
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 254));
      for (int k = 0; k < 3; k++) mem[$urandom_range(8'h40, 8'hFF)] = 8'hFF;
      reset = 1'b1;
      m_reset();
      tick();
      reset = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         rst_r = (m_halt && $urandom_range(0, 3) == 0) || ($urandom_range(0, 99) == 0);
         s_r   = ($urandom_range(0, 3) == 0);
         f_r   = ($urandom_range(0, 6) == 0);
         fj_r  = ($urandom_range(0, 9) == 0);
         reset = rst_r; stall = s_r; flush = f_r; force_j = fj_r;
         #1;
         exp_opc = (!m_boot && !m_halt) ? mem[m_pc][7:6] : 2'b00;
         chk("rnd_imem_addr", 16'(imem_addr), 16'(m_pc));
         chk("rnd_if_opcode", 16'(if_opcode), 16'(exp_opc));
         if (rst_r) m_reset();
         else m_step(s_r, f_r, fj_r);
         exp_q.push_back({m_pc, m_instr, m_idpc, m_valid, m_halt});
         tick();
         e = exp_q.pop_front();
         chk("rnd_pc",     16'(imem_addr), 16'(e[25:18]));
         chk("rnd_instr",  16'(id_instr),  16'(e[17:10]));
         chk("rnd_idpc",   16'(id_pc),     16'(e[9:2]));
         chk("rnd_valid",  16'(id_valid),  16'(e[1]));
         chk("rnd_halted", 16'(halted),    16'(e[0]));
`ifdef FETCH_PERF_CNT_EN
         chk("rnd_perf_f", perf_fetch_cnt, m_fcnt);
         chk("rnd_perf_j", perf_jump_cnt,  m_jcnt);
`endif
      end

      // ---- report ----
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
